// File: rtl/bram_exerciser.sv
// rtl/bram_exerciser.sv - on-chip BRAM test initiator: checksum, pattern fill, pattern check.
// Optional byte-lane write test is enabled by defining BRAM_EXERCISER_LANE_EN.
module bram_exerciser #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   seed,
   output logic [ADDR_WIDTH-1:0]   addr_a,
   input  logic [DATA_WIDTH-1:0]   q_a,
   output logic [DATA_WIDTH/8-1:0] we_b,
   output logic [ADDR_WIDTH-1:0]   addr_b,
   output logic [DATA_WIDTH-1:0]   din_b,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [15:0]             err_count,
   output logic [ADDR_WIDTH-1:0]   first_err_addr,
   output logic [DATA_WIDTH-1:0]   init_sum
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SUM,
      S_FILL,
      S_CHECK,
`ifdef BRAM_EXERCISER_LANE_EN
      S_LANE_FILL,
      S_LANE_CHECK,
`endif
      S_FINISH
   } state_t;

   state_t                 state;
   logic [DATA_WIDTH-1:0]  seed_l;
   logic                   drain;
   logic                   rd_vld;
   logic                   rd_chk;
   logic [ADDR_WIDTH-1:0]  rd_idx;
   logic [DATA_WIDTH-1:0]  exp_word;
   logic                   mismatch;
   logic [ADDR_WIDTH-1:0]  addr_b_nxt;
`ifdef BRAM_EXERCISER_LANE_EN
   logic                   rd_lane;
`endif

   function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] i);
      logic [DATA_WIDTH-1:0] z;
      z = DATA_WIDTH'(i);
      return seed_l ^ z ^ (z << 16);
   endfunction

`ifdef BRAM_EXERCISER_LANE_EN
   function automatic logic [LANES-1:0] lane_mask(input logic [ADDR_WIDTH-1:0] i);
      logic [LANES-1:0] m;
      for (int l = 0; l < LANES; l++)
         m[l] = (l == (int'(i) % LANES));
      return m;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] lane_pat(input logic [ADDR_WIDTH-1:0] i);
      logic [DATA_WIDTH-1:0] p;
      p = pat(i);
      for (int l = 0; l < LANES; l++)
         if (l == (int'(i) % LANES))
            p[l*8 +: 8] = 8'hA5;
      return p;
   endfunction
`endif

   // q_a returned this cycle belongs to rd_idx, presented one cycle earlier
   always_comb begin
      exp_word = pat(rd_idx);
`ifdef BRAM_EXERCISER_LANE_EN
      if (rd_lane)
         exp_word = lane_pat(rd_idx);
`endif
      mismatch   = rd_vld && rd_chk && (q_a != exp_word);
      addr_b_nxt = addr_b + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         seed_l         <= '0;
         drain          <= 1'b0;
         rd_vld         <= 1'b0;
         rd_chk         <= 1'b0;
         rd_idx         <= '0;
         addr_a         <= '0;
         addr_b         <= '0;
         we_b           <= '0;
         din_b          <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         init_sum       <= '0;
`ifdef BRAM_EXERCISER_LANE_EN
         rd_lane        <= 1'b0;
`endif
      end else begin
         rd_vld <= 1'b0;
         if (rd_vld && !rd_chk)
            init_sum <= init_sum + q_a;
         if (mismatch) begin
            if (err_count != 16'hFFFF)
               err_count <= err_count + 16'd1;
            if (err_count == 16'd0)
               first_err_addr <= rd_idx;
         end

         case (state)
            S_IDLE: begin
               we_b <= '0;
               done <= 1'b0;
               if (start) begin
                  seed_l         <= seed;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  init_sum       <= '0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
                  addr_a         <= '0;
                  drain          <= 1'b0;
                  state          <= S_SUM;
               end
            end

            S_SUM,
`ifdef BRAM_EXERCISER_LANE_EN
            S_LANE_CHECK,
`endif
            S_CHECK: begin
               if (!drain) begin
                  rd_vld <= 1'b1;
                  rd_chk <= (state != S_SUM);
                  rd_idx <= addr_a;
`ifdef BRAM_EXERCISER_LANE_EN
                  rd_lane <= (state == S_LANE_CHECK);
`endif
                  if (addr_a == LAST) begin
                     addr_a <= '0;
                     drain  <= 1'b1;
                  end else begin
                     addr_a <= addr_a + 1'b1;
                  end
               end else begin
                  drain <= 1'b0;
                  if (state == S_SUM) begin
                     state  <= S_FILL;
                     addr_b <= '0;
                     we_b   <= '1;
                     din_b  <= pat('0);
                  end
`ifdef BRAM_EXERCISER_LANE_EN
                  else if (state == S_CHECK) begin
                     state  <= S_LANE_FILL;
                     addr_b <= '0;
                     we_b   <= lane_mask('0);
                     din_b  <= {LANES{8'hA5}};
                  end
`endif
                  else begin
                     // last compare lands on this edge, so fold it into pass
                     state <= S_FINISH;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_count == 16'd0) && !mismatch;
                  end
               end
            end

            S_FILL: begin
               if (addr_b == LAST) begin
                  addr_b <= '0;
                  we_b   <= '0;
                  din_b  <= '0;
                  addr_a <= '0;
                  state  <= S_CHECK;
               end else begin
                  addr_b <= addr_b_nxt;
                  din_b  <= pat(addr_b_nxt);
               end
            end

`ifdef BRAM_EXERCISER_LANE_EN
            S_LANE_FILL: begin
               if (addr_b == LAST) begin
                  addr_b <= '0;
                  we_b   <= '0;
                  din_b  <= '0;
                  addr_a <= '0;
                  state  <= S_LANE_CHECK;
               end else begin
                  addr_b <= addr_b_nxt;
                  we_b   <= lane_mask(addr_b_nxt);
               end
            end
`endif

            S_FINISH: begin
               done   <= 1'b0;
               addr_a <= '0;
               addr_b <= '0;
               state  <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_exerciser.sv
// tb/tb_bram_exerciser.sv - directed bench for bram_exerciser with a behavioral byte-write RAM.
// Build with BRAM_EXERCISER_LANE_EN defined to cover the lane test.
module tb_bram_exerciser;

`ifdef BRAM_EXERCISER_LANE_EN
   localparam int BUSY_CYC = 5123;
   localparam int LANE_MUL = 2;
`else
   localparam int BUSY_CYC = 3074;
   localparam int LANE_MUL = 1;
`endif

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] seed_in;
   logic [9:0]  addr_a;
   logic [31:0] q_a;
   logic [3:0]  we_b;
   logic [9:0]  addr_b;
   logic [31:0] din_b;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] err_count;
   logic [9:0]  first_err_addr;
   logic [31:0] init_sum;

   logic [31:0] mem [0:1023];
   int          fault;
   logic        preload;
   int          pre_kind;

   int n_tests = 0;
   int n_fail  = 0;

   bram_exerciser dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .seed           (seed_in),
      .addr_a         (addr_a),
      .q_a            (q_a),
      .we_b           (we_b),
      .addr_b         (addr_b),
      .din_b          (din_b),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .init_sum       (init_sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // fault 1: bit 0 forced high at 5 and 9 (seed 1 makes those pattern bits zero)
   // fault 2: every read inverted; fault 3: lane 2 write enable ignored
   always @(posedge clk) begin
      logic [31:0] r;
      r = mem[addr_a];
      if (fault == 1 && (addr_a == 10'd5 || addr_a == 10'd9)) r[0] = 1'b1;
      if (fault == 2) r = ~r;
      q_a <= r;
      if (preload) begin
         for (int i = 0; i < 1024; i++)
            mem[i] <= (pre_kind == 1) ? i : 32'd0;
      end else begin
         for (int l = 0; l < 4; l++)
            if (we_b[l] && !(fault == 3 && l == 2))
               mem[addr_b][l*8 +: 8] <= din_b[l*8 +: 8];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load(input int kind);
      @(negedge clk);
      pre_kind = kind;
      preload  = 1'b1;
      @(negedge clk);
      preload  = 1'b0;
   endtask

   task automatic run(input logic [31:0] s, input int pulse_at, output int cyc);
      @(negedge clk);
      seed_in = s;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      check("start_busy", busy, 1);
      check("start_addr_a", addr_a, 0);
      cyc = 0;
      while (busy && cyc < 20000) begin
         cyc++;
         start = (cyc == pulse_at);
         @(negedge clk);
      end
      start = 1'b0;
      check("done_pulse", done, 1);
   endtask

   initial begin
      int cyc;
      int w;
      rst      = 1'b1;
      start    = 1'b0;
      seed_in  = '0;
      fault    = 0;
      preload  = 1'b0;
      pre_kind = 0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_we_b", we_b, 0);
      check("rst_addr", {addr_a, addr_b}, 0);
      check("rst_init_sum", init_sum, 0);
      check("rst_err", {err_count, first_err_addr, pass}, 0);
      rst = 1'b0;

      // zero-filled RAM, seed 0
      load(0);
      run(32'h0, 0, cyc);
      check("t1_busy_cycles", cyc, BUSY_CYC);
      check("t1_init_sum", init_sum, 0);
      check("t1_pass", pass, 1);
      check("t1_err", err_count, 0);
      @(negedge clk);
      check("t1_done_one_cycle", done, 0);
`ifdef BRAM_EXERCISER_LANE_EN
      check("t1_mem1", mem[1], 32'h0001A501);
      check("t1_mem1023", mem[1023], 32'hA5FF03FF);
`else
      check("t1_mem1", mem[1], 32'h00010001);
      check("t1_mem1023", mem[1023], 32'h03FF03FF);
`endif

      // mem[i] = i
      load(1);
      run(32'h0, 0, cyc);
      check("t2_init_sum", init_sum, 32'd523776);
      check("t2_pass", pass, 1);

      // two faulty cells
      load(0);
      fault = 1;
      run(32'h1, 0, cyc);
      fault = 0;
      check("t3_err", err_count, 2 * LANE_MUL);
      check("t3_first", first_err_addr, 5);
      check("t3_pass", pass, 0);
      check("t3_init_sum", init_sum, 2);

      // reset in the middle of FILL
      load(1);
      @(negedge clk);
      seed_in = 32'h0BAD_F00D;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      w = 0;
      while (addr_b != 10'd300 && w < 5000) begin
         w++;
         @(negedge clk);
      end
      check("t4_at_300", addr_b, 300);
      check("t4_we_fill", we_b, 4'hF);
      check("t4_sum_before", init_sum, 32'd523776);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t4_busy", busy, 0);
      check("t4_we_b", we_b, 0);
      check("t4_din_b", din_b, 0);
      check("t4_addr", {addr_a, addr_b}, 0);
      check("t4_init_sum", init_sum, 0);
      check("t4_flags", {done, pass, err_count, first_err_addr}, 0);
      run(32'h0BAD_F00D, 0, cyc);
      check("t4_rerun_cycles", cyc, BUSY_CYC);
      check("t4_rerun_pass", pass, 1);

      // every read inverted, start pulsed mid-run
      fault = 2;
      run(32'hDEAD_BEEF, 500, cyc);
      fault = 0;
      check("t5_err", err_count, 1024 * LANE_MUL);
      check("t5_first", first_err_addr, 0);
      check("t5_pass", pass, 0);
      check("t5_busy_cycles", cyc, BUSY_CYC);
      @(negedge clk);
      check("t5_idle_after", busy, 0);

`ifdef BRAM_EXERCISER_LANE_EN
      load(0);
      run(32'h12345678, 0, cyc);
      check("t6_mem1", mem[1], 32'h1235A579);
      check("t6_pass", pass, 1);
      check("t6_busy_cycles", cyc, 5123);
      fault = 3;
      run(32'h12345678, 0, cyc);
      fault = 0;
      check("t7_err", err_count, 256);
      check("t7_first", first_err_addr, 2);
      check("t7_pass", pass, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
